// File: rtl/sequenciador_posicao_pkg.sv
// rtl/sequenciador_posicao_pkg.sv - decoder codes, decoder error states and FSM encoding
// Shared by sequenciador_posicao and sequenciador_passo.
package sequenciador_posicao_pkg;

  localparam logic [6:0] C1 = 7'b0000001;
  localparam logic [6:0] C2 = 7'b0000010;
  localparam logic [6:0] C3 = 7'b0000100;
  localparam logic [6:0] C4 = 7'b0001000;
  localparam logic [6:0] C5 = 7'b0010000;
  localparam logic [6:0] C6 = 7'b0100000;
  localparam logic [6:0] C7 = 7'b1000000;
  localparam logic [6:0] C8 = 7'b1111111;

  localparam logic [3:0] EST_ERRO_A = 4'd8;
  localparam logic [3:0] EST_ERRO_B = 4'd9;
  localparam logic [3:0] EST_ERRO_C = 4'd10;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    EMITE    = 3'd1,
    ESPERA   = 3'd2,
    PRONTO   = 3'd3,
    FALHA    = 3'd4,
    RECUPERA = 3'd5
  } estado_fsm_t;

  function automatic logic [6:0] codigo_de(input logic [2:0] pos);
    case (pos)
      3'd1:    codigo_de = C1;
      3'd2:    codigo_de = C2;
      3'd3:    codigo_de = C3;
      3'd4:    codigo_de = C4;
      3'd5:    codigo_de = C5;
      default: codigo_de = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/sequenciador_passo.sv
// rtl/sequenciador_passo.sv - next step position and its decoder code
// SEQ_SALTO_DIRETO_EN: from position 0, jump straight to the target (3 goes via 4).
module sequenciador_passo
  import sequenciador_posicao_pkg::*;
(
  input  logic [2:0] i_pos,
  input  logic [2:0] i_alvo,
  output logic [2:0] o_passo,
  output logic [6:0] o_codigo
);

  always_comb begin
    o_passo = (i_alvo > i_pos) ? i_pos + 3'd1 : i_pos - 3'd1;
`ifdef SEQ_SALTO_DIRETO_EN
    if (i_pos == 3'd0) begin
      o_passo = (i_alvo == 3'd3) ? 3'd4 : i_alvo;
    end
`else
`endif
    o_codigo = codigo_de(o_passo);
  end

endmodule

// File: rtl/sequenciador_posicao.sv
// rtl/sequenciador_posicao.sv - steps a position decoder to a target one code at a time
// Optional direct jump from position 0 under SEQ_SALTO_DIRETO_EN (see sequenciador_passo).
module sequenciador_posicao
  import sequenciador_posicao_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int NPOS    = 6
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Pedido,
  input  logic [2:0] Alvo,
  input  logic [3:0] Estado,
  output logic [6:0] Entrada,
  output logic       Controle,
  output logic       DecReset,
  output logic       Ocupado,
  output logic       Pronto,
  output logic       Erro
);

  estado_fsm_t r_estado;
  estado_fsm_t w_prox;
  logic [2:0]  r_alvo;
  logic [2:0]  r_passo;
  logic [3:0]  r_timer;
  logic        r_rejeita;

  logic [2:0]  w_passo;
  logic [6:0]  w_codigo;
  logic [3:0]  w_timer_inc;
  logic        w_alvo_invalido;
  logic        w_chegou;
  logic        w_timeout;

  assign w_alvo_invalido = (Alvo == 3'd0) || (32'(Alvo) >= 32'(NPOS));
  assign w_timer_inc     = (r_timer == 4'hF) ? r_timer : r_timer + 4'd1;
  assign w_timeout       = 32'(w_timer_inc) >= 32'(TIMEOUT);
  assign w_chegou        = (Estado == {1'b0, r_passo});

  sequenciador_passo u_passo (
    .i_pos   (Estado[2:0]),
    .i_alvo  (r_alvo),
    .o_passo (w_passo),
    .o_codigo(w_codigo)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Timer counts from the strobe cycle itself and restarts on every new strobe
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_alvo    <= 3'd0;
      r_passo   <= 3'd0;
      r_timer   <= 4'd0;
      r_rejeita <= 1'b0;
    end else begin
      r_rejeita <= (r_estado == OCIOSO) && Pedido && w_alvo_invalido;
      if ((r_estado == OCIOSO) && Pedido && !w_alvo_invalido) begin
        r_alvo <= Alvo;
      end
      if (r_estado == EMITE) begin
        r_passo <= w_passo;
      end
      if ((w_prox == EMITE) || !((r_estado == EMITE) || (r_estado == ESPERA))) begin
        r_timer <= 4'd0;
      end else begin
        r_timer <= w_timer_inc;
      end
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (Pedido && !w_alvo_invalido) begin
          if (Estado[3])                   w_prox = FALHA;
          else if (Estado == {1'b0, Alvo}) w_prox = PRONTO;
          else                             w_prox = EMITE;
        end
      end
      EMITE:  w_prox = ESPERA;
      ESPERA: begin
        if (w_chegou)                  w_prox = (r_passo == r_alvo) ? PRONTO : EMITE;
        else if (Estado[3] || w_timeout) w_prox = FALHA;
      end
      PRONTO:   w_prox = OCIOSO;
      FALHA:    w_prox = RECUPERA;
      RECUPERA: w_prox = OCIOSO;
      default:  w_prox = OCIOSO;
    endcase
  end

  always_comb begin
    Ocupado  = (r_estado != OCIOSO);
    Controle = (r_estado == EMITE);
    Entrada  = (r_estado == EMITE) ? w_codigo : 7'd0;
    Pronto   = (r_estado == PRONTO);
    Erro     = (r_estado == FALHA) || r_rejeita;
    DecReset = (r_estado == RECUPERA);
  end

endmodule

// File: tb/tb_sequenciador_posicao.sv
// tb/tb_sequenciador_posicao.sv - directed scoreboard bench for sequenciador_posicao
module tb_sequenciador_posicao;

  localparam int TIMEOUT = 8;
  localparam int NPOS    = 6;

  logic       clk;
  logic       Reset;
  logic       Pedido;
  logic [2:0] Alvo;
  logic [3:0] Estado;
  logic [6:0] Entrada;
  logic       Controle;
  logic       DecReset;
  logic       Ocupado;
  logic       Pronto;
  logic       Erro;

  sequenciador_posicao #(.TIMEOUT(TIMEOUT), .NPOS(NPOS)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .Pedido  (Pedido),
    .Alvo    (Alvo),
    .Estado  (Estado),
    .Entrada (Entrada),
    .Controle(Controle),
    .DecReset(DecReset),
    .Ocupado (Ocupado),
    .Pronto  (Pronto),
    .Erro    (Erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cycle = 0;
  int         t_strobe = 0, t_erro = 0, t_dec = 0, t_pronto = 0, n_strobe = 0;
  int         n0, t0;
  bit         dec_auto = 0;
  bit         pend_v = 0;
  logic [3:0] pend = 4'd0;
  logic [9:0] sb[$];

  localparam logic [2:0] K_STB = 3'd1, K_PRT = 3'd2, K_ERR = 3'd3, K_DRS = 3'd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] cod(input int k);
    logic [6:0] v;
    v = 7'd1 << (k - 1);
    return v;
  endfunction

  function automatic logic [3:0] pos_of(input logic [6:0] c);
    logic [3:0] p;
    p = 4'd0;
    for (int b = 0; b < 7; b++) if (c[b]) p = 4'(b + 1);
    return p;
  endfunction

  task automatic ev(input logic [9:0] obs);
    logic [9:0] exp;
    if (sb.size() == 0) begin
      chk("unexpected_event", 32'(obs), 32'd0);
    end else begin
      exp = sb.pop_front();
      chk("event", 32'(obs), 32'(exp));
    end
  endtask

  // One clock: observe outputs after the edge, then the decoder model reacts
  task automatic cyc();
    logic       stb;
    logic [6:0] ent;
    @(posedge clk);
    #1;
    cycle++;
    stb = Controle;
    ent = Entrada;
    if (stb) begin
      ev({K_STB, ent});
      t_strobe = cycle;
      n_strobe++;
    end else begin
      chk("entrada_idle", 32'(ent), 32'd0);
    end
    if (Pronto)   begin ev({K_PRT, 7'd0}); t_pronto = cycle; end
    if (Erro)     begin ev({K_ERR, 7'd0}); t_erro   = cycle; end
    if (DecReset) begin ev({K_DRS, 7'd0}); t_dec    = cycle; end
    if (pend_v) begin
      Estado = pend;
      pend_v = 0;
    end
    if (stb && dec_auto) begin
      pend   = pos_of(ent);
      pend_v = 1;
    end
  endtask

  task automatic req(input logic [2:0] a);
    Alvo   = a;
    Pedido = 1'b1;
    cyc();
    Pedido = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (!Ocupado) break;
      cyc();
    end
    chk({tag, "_idle"}, 32'(Ocupado), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_entrada"},  32'(Entrada),  32'd0);
    chk({tag, "_controle"}, 32'(Controle), 32'd0);
    chk({tag, "_decreset"}, 32'(DecReset), 32'd0);
    chk({tag, "_ocupado"},  32'(Ocupado),  32'd0);
    chk({tag, "_pronto"},   32'(Pronto),   32'd0);
    chk({tag, "_erro"},     32'(Erro),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    Pedido = 1'b0;
    Alvo   = 3'd0;
    Estado = 4'd0;
    cyc();
    cyc();
    chk_all_zero("reset");
    Reset = 1'b0;
    cyc();

    // 1 -> 4 through C2, C3, C4; busy-time Pedido and Alvo changes are ignored
    Estado   = 4'd1;
    dec_auto = 1;
    n0 = n_strobe;
    sb.push_back({K_STB, cod(2)});
    sb.push_back({K_STB, cod(3)});
    sb.push_back({K_STB, cod(4)});
    sb.push_back({K_PRT, 7'd0});
    req(3'd4);
    chk("t1_ocupado", 32'(Ocupado), 32'd1);
    Alvo   = 3'd5;
    Pedido = 1'b1;
    cyc();
    Pedido = 1'b0;
    Alvo   = 3'd0;
    drain("t1", 60);
    chk("t1_strobes", 32'(n_strobe - n0), 32'd3);

    // Already at target: Pronto one cycle after the request cycle, no strobe
    dec_auto = 0;
    Estado   = 4'd3;
    n0 = n_strobe;
    sb.push_back({K_PRT, 7'd0});
    t0 = cycle;
    req(3'd3);
    chk("t2_pronto_lat", 32'(t_pronto - t0), 32'd1);
    drain("t2", 10);
    chk("t2_strobes", 32'(n_strobe - n0), 32'd0);

    // Decoder never moves: Erro TIMEOUT cycles after the strobe, DecReset next
    Estado = 4'd2;
    sb.push_back({K_STB, cod(3)});
    sb.push_back({K_ERR, 7'd0});
    sb.push_back({K_DRS, 7'd0});
    req(3'd3);
    drain("t3", 40);
    chk("t3_erro_lat", 32'(t_erro - t_strobe), 32'(TIMEOUT));
    chk("t3_dec_lat",  32'(t_dec - t_erro), 32'd1);

    // Decoder reports an error code after C3
    Estado = 4'd2;
    sb.push_back({K_STB, cod(3)});
    sb.push_back({K_ERR, 7'd0});
    sb.push_back({K_DRS, 7'd0});
    req(3'd5);
    Estado = 4'd8;
    drain("t4", 20);
    chk("t4_erro_lat", 32'(t_erro - t_strobe), 32'd2);
    chk("t4_dec_lat",  32'(t_dec - t_erro), 32'd1);

    // From 0 to 5
    Estado   = 4'd0;
    dec_auto = 1;
    n0 = n_strobe;
`ifdef SEQ_SALTO_DIRETO_EN
    sb.push_back({K_STB, cod(5)});
`else
    for (int k = 1; k <= 5; k++) sb.push_back({K_STB, cod(k)});
`endif
    sb.push_back({K_PRT, 7'd0});
    req(3'd5);
    drain("t5", 80);
`ifdef SEQ_SALTO_DIRETO_EN
    chk("t5_strobes", 32'(n_strobe - n0), 32'd1);
`else
    chk("t5_strobes", 32'(n_strobe - n0), 32'd5);
`endif

    // Invalid targets: single Erro pulse, never busy
    dec_auto = 0;
    Estado   = 4'd2;
    n0 = n_strobe;
    sb.push_back({K_ERR, 7'd0});
    req(3'd0);
    chk("t6_zero_ocupado", 32'(Ocupado), 32'd0);
    cyc();
    chk("t6_zero_pulse", 32'(Erro), 32'd0);
    sb.push_back({K_ERR, 7'd0});
    req(3'(NPOS));
    chk("t6_npos_ocupado", 32'(Ocupado), 32'd0);
    cyc();
    chk("t6_npos_pulse", 32'(Erro), 32'd0);
    chk("t6_strobes", 32'(n_strobe - n0), 32'd0);

    // Reset while waiting, then reset beating a same-cycle request
    Estado = 4'd0;
`ifdef SEQ_SALTO_DIRETO_EN
    sb.push_back({K_STB, cod(2)});
`else
    sb.push_back({K_STB, cod(1)});
`endif
    req(3'd2);
    cyc();
    chk("t7_ocupado_espera", 32'(Ocupado), 32'd1);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk_all_zero("t7_reset");
    chk("t7_sb", 32'(sb.size()), 32'd0);
    Reset  = 1'b1;
    Pedido = 1'b1;
    Alvo   = 3'd3;
    cyc();
    Reset  = 1'b0;
    Pedido = 1'b0;
    chk("t7_prio_ocupado", 32'(Ocupado), 32'd0);
    cyc();
    chk("t7_after_ocupado", 32'(Ocupado), 32'd0);
    n0 = n_strobe;
    sb.push_back({K_ERR, 7'd0});
    req(3'd7);
    chk("t7_alvo7_ocupado", 32'(Ocupado), 32'd0);
    cyc();
    chk("t7_alvo7_pulse", 32'(Erro), 32'd0);
    chk("t7_alvo7_strobes", 32'(n_strobe - n0), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_posicao.md
SEQUENCIADOR_POSICAO -- requirements
Module: sequenciador_posicao

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning max wait cycles for the decoder to reach the expected state.
REQ-002 SHALL have parameter NPOS, default 6, meaning number of valid positions (0..NPOS-1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Pedido  input  1  move request, qualified while Ocupado=0.
REQ-006 SHALL have port Alvo  input  3  target position.
REQ-007 SHALL have port Estado  input  4  current decoder state (0..5 position; 8/9/10 error codes).
REQ-008 SHALL have port Entrada  output  7  code driven to the decoder; 0 when not strobing.
REQ-009 SHALL have port Controle  output  1  one-cycle strobe qualifying Entrada.
REQ-010 SHALL have port DecReset  output  1  one-cycle decoder reset request on recovery.
REQ-011 SHALL have ports Ocupado, Pronto, Erro  output  1 each  busy level, done pulse, error pulse.

Function
REQ-012 SHALL implement FSM states OCIOSO, EMITE, ESPERA, PRONTO, FALHA, RECUPERA.
REQ-013 OCIOSO: Pedido=1 SHALL latch Alvo; next state EMITE, Ocupado=1 from next cycle.
REQ-014 Alvo >= NPOS or Alvo=0 SHALL give Erro=1 for one cycle, no strobe, stay OCIOSO.
REQ-015 Alvo equal to Estado SHALL go directly to PRONTO, no strobe.
REQ-016 Code Ck (k=1..5) SHALL mean "move to position k"; step target = Estado+1 if Alvo>Estado, else Estado-1.
REQ-017 EMITE SHALL drive Entrada=code(step) with Controle=1 for exactly one cycle, then ESPERA with timer cleared.
REQ-018 ESPERA: Estado==step SHALL go PRONTO if step==Alvo, else EMITE; earliest check is the cycle after the strobe.
REQ-019 ESPERA: Estado[3]=1, or timer reaching TIMEOUT, SHALL go FALHA.
REQ-020 FALHA SHALL pulse Erro one cycle, then RECUPERA; RECUPERA SHALL pulse DecReset one cycle, then OCIOSO.
REQ-021 PRONTO SHALL pulse Pronto one cycle, then OCIOSO; Ocupado=0 in OCIOSO only.
REQ-022 Pedido during Ocupado=1 SHALL be ignored; Alvo changes after latch SHALL be ignored.
REQ-023 Timer SHALL be 4 bits, saturating, never wrapping.

Reset
REQ-024 Reset=1 at a clock edge SHALL force OCIOSO, clear latched target and timer, set all outputs 0, including mid-operation.
REQ-025 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-026 Macro SEQ_SALTO_DIRETO_EN defined: from Estado=0 with Alvo in {1,2,4,5}, SHALL emit code(Alvo) as a single step; Alvo=3 SHALL emit C4 then C3.
REQ-027 Macro undefined: from Estado=0 SHALL always step via C1 and adjacent steps only.

Structure
REQ-028 Shared package SHALL hold code constants C1..C8 (C1=7'b0000001, C2=7'b0000010, C3=7'b0000100, C4=7'b0001000, C5=7'b0010000, C6=7'b0100000, C7=7'b1000000, C8=7'b1111111), error state values (8, 9, 10) and the FSM state encoding.
REQ-029 One sub-module, sequenciador_passo, SHALL compute the step target and code from (Estado, Alvo); the rest is flat.

Verification
REQ-030 Estado=1, Pedido with Alvo=4 -> strobes C2, C3, C4, each one cycle after Estado matches; Pronto after Estado=4.
REQ-031 Estado=3, Alvo=3 -> Pronto 1 cycle after OCIOSO sample, Controle never 1.
REQ-032 Estado=2, Alvo=3, Estado held at 2 -> Erro at 8 cycles after strobe, DecReset next cycle, then OCIOSO.
REQ-033 Estado=2, Alvo=5, Estado goes to 8 after C3 -> FALHA, Erro pulse, DecReset pulse.
REQ-034 Estado=0, Alvo=5: with SEQ_SALTO_DIRETO_EN single C5 strobe; without, C1..C5 in order.
REQ-035 Reset asserted in ESPERA -> next cycle all outputs 0, OCIOSO; Alvo=7 -> Erro pulse only.
